// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB word-addressed memory slave with byte strobes, wait states and range error
module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);
  localparam int SW = DATA_W / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  logic err, done, busy;
  assign idx  = paddr[IW-1:0];
  assign err  = {1'b0, paddr} >= (ADDR_W+1)'(DEPTH);
  assign busy = state == ACCESS && psel && penable;
  assign done = busy && cnt == 4'(WAIT_CYCLES);
  assign pready  = done;
  assign pslverr = done && err;
  assign prdata  = done && !pwrite && !err ? mem[idx] : '0;
  // every exit from ACCESS (completion or dropped select) returns to IDLE
  always_comb begin
    state_n = state == IDLE  ? (psel && !penable ? SETUP : IDLE) :
              state == SETUP ? ACCESS :
              busy && !done  ? ACCESS : IDLE;
    cnt_n   = state == SETUP ? 4'd0 : busy && !done ? cnt + 4'd1 : cnt;
  end
  always_ff @(posedge pclk or negedge preset)
    if (!preset) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (done && pwrite && !err)
        for (int b = 0; b < SW; b++)
          if (pstrb[b]) mem[idx][8*b +: 8] <= pwdata[8*b +: 8];
    end
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: directed checks of three slave instances (0, 2 and 3 wait states)
module tb_apb_mem_slave;
  logic pclk = 0, preset = 0, psel = 0, penable = 0, pwrite = 0;
  logic [7:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0] pstrb = '0;
  logic [31:0] prd [3];
  logic prdy [3], perr [3];
  logic pready_m, pslverr_m;
  logic [31:0] prdata_m;
  int cur = 0, errors = 0, checks = 0;
  int nw;
  logic e;
  logic [31:0] rd;

  always #5 pclk = ~pclk;

  apb_mem_slave u0 (.pclk(pclk), .preset(preset), .psel(psel && cur == 0), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prd[0]), .pready(prdy[0]), .pslverr(perr[0]));
  apb_mem_slave #(.WAIT_CYCLES(2)) u2 (.pclk(pclk), .preset(preset), .psel(psel && cur == 1),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prd[1]), .pready(prdy[1]), .pslverr(perr[1]));
  apb_mem_slave #(.WAIT_CYCLES(3)) u3 (.pclk(pclk), .preset(preset), .psel(psel && cur == 2),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prd[2]), .pready(prdy[2]), .pslverr(perr[2]));

  assign pready_m  = prdy[cur];
  assign pslverr_m = perr[cur];
  assign prdata_m  = prd[cur];

  // nw = ACCESS cycles with pready low; -1 if pready rose during SETUP, 20 on timeout
  task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output int n, output logic er, output logic [31:0] r);
    @(posedge pclk); #1 psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = wd; pstrb = st;
    @(posedge pclk); #1 penable = 1;
    n = pready_m ? -1 : 0;
    if (n == 0) begin
      @(posedge pclk); #1;
      while (!pready_m && n < 20) begin n++; @(posedge pclk); #1; end
    end
    er = pslverr_m;
    r = prdata_m;
  endtask

  task automatic idle();
    @(posedge pclk); #1 psel = 0; penable = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge pclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (prdy[i] !== 1'b0 || perr[i] !== 1'b0 || prd[i] !== 32'h0) begin
        errors++; $display("FAIL reset_out[%0d] pready=%b pslverr=%b prdata=%h exp 0/0/0", i, prdy[i], perr[i], prd[i]); end
    end
    preset = 1;
  endtask

  task automatic test_basic();
    cur = 0;
    xfer(1, 3, 32'hDEADBEEF, 4'hF, nw, e, rd);
    checks++; if (nw !== 0 || e !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL basic_wr waits=%0d err=%b prdata=%h exp 0/0/0", nw, e, rd); end
    xfer(0, 3, 32'h0, 4'h0, nw, e, rd);
    checks++; if (nw !== 0 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_rd waits=%0d err=%b prdata=%h exp 0/0/deadbeef", nw, e, rd); end
    idle();
    #1;
    checks++; if (pready_m !== 1'b0 || prdata_m !== 32'h0) begin
      errors++; $display("FAIL basic_idle pready=%b prdata=%h exp 0/0", pready_m, prdata_m); end
  endtask

  task automatic test_strobes();
    cur = 0;
    xfer(1, 5, 32'h11223344, 4'hF, nw, e, rd);
    xfer(1, 5, 32'hAABBCCDD, 4'h5, nw, e, rd);
    xfer(0, 5, 32'h0, 4'h0, nw, e, rd);
    checks++; if (rd !== 32'h11BB33DD || e !== 1'b0) begin
      errors++; $display("FAIL strobe_rd prdata=%h err=%b exp 11bb33dd/0", rd, e); end
    xfer(1, 5, 32'hFFFFFFFF, 4'h0, nw, e, rd);
    checks++; if (nw !== 0 || e !== 1'b0) begin
      errors++; $display("FAIL strobe_zero_wr waits=%0d err=%b exp 0/0", nw, e); end
    xfer(0, 5, 32'h0, 4'h0, nw, e, rd);
    checks++; if (rd !== 32'h11BB33DD) begin
      errors++; $display("FAIL strobe_zero_rd prdata=%h exp 11bb33dd", rd); end
    idle();
  endtask

  task automatic test_error();
    cur = 0;
    xfer(1, 20, 32'h55, 4'hF, nw, e, rd);
    checks++; if (nw !== 0 || e !== 1'b1) begin
      errors++; $display("FAIL err_wr waits=%0d pslverr=%b exp 0/1", nw, e); end
    xfer(0, 20, 32'h0, 4'h0, nw, e, rd);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_rd pslverr=%b prdata=%h exp 1/0", e, rd); end
    xfer(0, 4, 32'h0, 4'h0, nw, e, rd);
    checks++; if (e !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL err_alias pslverr=%b prdata=%h exp 0/0", e, rd); end
    xfer(0, 15, 32'h0, 4'h0, nw, e, rd);
    checks++; if (e !== 1'b0) begin
      errors++; $display("FAIL err_last_word pslverr=%b exp 0", e); end
    xfer(0, 16, 32'h0, 4'h0, nw, e, rd);
    checks++; if (e !== 1'b1) begin
      errors++; $display("FAIL err_depth pslverr=%b exp 1", e); end
    idle();
  endtask

  task automatic test_back_to_back();
    cur = 0;
    xfer(1, 7, 32'hA5A5A5A5, 4'hF, nw, e, rd);
    checks++; if (nw !== 0) begin errors++; $display("FAIL b2b_wr0 waits=%0d exp 0", nw); end
    xfer(1, 8, 32'h5A5A5A5A, 4'hF, nw, e, rd);
    checks++; if (nw !== 0) begin errors++; $display("FAIL b2b_wr1 waits=%0d exp 0", nw); end
    xfer(0, 7, 32'h0, 4'h0, nw, e, rd);
    checks++; if (nw !== 0 || rd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL b2b_rd0 waits=%0d prdata=%h exp 0/a5a5a5a5", nw, rd); end
    xfer(0, 8, 32'h0, 4'h0, nw, e, rd);
    checks++; if (nw !== 0 || rd !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL b2b_rd1 waits=%0d prdata=%h exp 0/5a5a5a5a", nw, rd); end
    idle();
  endtask

  task automatic test_wait();
    cur = 1;
    xfer(1, 1, 32'h12345678, 4'hF, nw, e, rd);
    checks++; if (nw !== 2 || e !== 1'b0) begin
      errors++; $display("FAIL wait_wr waits=%0d err=%b exp 2/0", nw, e); end
    xfer(0, 1, 32'h0, 4'h0, nw, e, rd);
    checks++; if (nw !== 2 || rd !== 32'h12345678) begin
      errors++; $display("FAIL wait_rd waits=%0d prdata=%h exp 2/12345678", nw, rd); end
    idle();
    @(posedge pclk); #1 psel = 1; penable = 0; pwrite = 1; paddr = 1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1;
    @(posedge pclk); #1;
    checks++; if (pready_m !== 1'b0 || pslverr_m !== 1'b0) begin
      errors++; $display("FAIL abort_access pready=%b pslverr=%b exp 0/0", pready_m, pslverr_m); end
    psel = 0; penable = 0;
    repeat (3) @(posedge pclk);
    xfer(0, 1, 32'h0, 4'h0, nw, e, rd);
    checks++; if (nw !== 2 || rd !== 32'h12345678) begin
      errors++; $display("FAIL abort_rd waits=%0d prdata=%h exp 2/12345678", nw, rd); end
    idle();
  endtask

  task automatic test_reset_abort();
    cur = 2;
    xfer(1, 2, 32'h77, 4'hF, nw, e, rd);
    checks++; if (nw !== 3) begin errors++; $display("FAIL rst_pre_wr waits=%0d exp 3", nw); end
    idle();
    @(posedge pclk); #1 psel = 1; penable = 0; pwrite = 1; paddr = 2; pwdata = 32'h99; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1;
    @(posedge pclk); #1;
    @(posedge pclk); #1 preset = 0;
    #1;
    checks++; if (pready_m !== 1'b0 || pslverr_m !== 1'b0 || prdata_m !== 32'h0) begin
      errors++; $display("FAIL rst_abort_out pready=%b pslverr=%b prdata=%h exp 0/0/0", pready_m, pslverr_m, prdata_m); end
    @(posedge pclk); #1 preset = 1; psel = 0; penable = 0;
    xfer(0, 2, 32'h0, 4'h0, nw, e, rd);
    checks++; if (nw !== 3 || rd !== 32'h0) begin
      errors++; $display("FAIL rst_abort_rd waits=%0d prdata=%h exp 3/0", nw, rd); end
    xfer(1, 2, 32'hCAFE, 4'hF, nw, e, rd);
    xfer(0, 2, 32'h0, 4'h0, nw, e, rd);
    checks++; if (nw !== 3 || rd !== 32'hCAFE) begin
      errors++; $display("FAIL rst_after_rd waits=%0d prdata=%h exp 3/cafe", nw, rd); end
    idle();
    cur = 0;
    xfer(0, 3, 32'h0, 4'h0, nw, e, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_clear_u0 prdata=%h exp 0", rd); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobes();
    test_error();
    test_back_to_back();
    test_wait();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, read/write data width; legal values 8, 16, 32.
REQ-002 SHALL have parameter ADDR_W, default 8, width of paddr; paddr is a word index, not a byte address.
REQ-003 SHALL have parameter DEPTH, default 16, number of storage words; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, wait states inserted in every access phase; range 0-15.
REQ-005 SHALL have port pclk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port preset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port psel  input  1  slave select.
REQ-008 SHALL have port penable  input  1  access-phase indicator.
REQ-009 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-010 SHALL have port paddr  input  ADDR_W  word index.
REQ-011 SHALL have port pwdata  input  DATA_W  write data.
REQ-012 SHALL have port pstrb  input  DATA_W/8  per-byte write enables.
REQ-013 SHALL have port prdata  output  DATA_W  read data.
REQ-014 SHALL have port pready  output  1  transfer complete.
REQ-015 SHALL have port pslverr  output  1  transfer error, valid only while pready=1.

Function
REQ-016 SHALL implement states IDLE, SETUP and ACCESS.
REQ-017 IDLE: psel=1 and penable=0 -> SETUP; otherwise stay in IDLE.
REQ-018 SETUP SHALL always go to ACCESS on the next edge and clear the wait counter to 0.
REQ-019 ACCESS SHALL increment the wait counter each cycle while the counter < WAIT_CYCLES.
REQ-020 pready SHALL be combinational: 1 only when state=ACCESS, psel=1, penable=1 and counter=WAIT_CYCLES; 0 otherwise.
REQ-021 WAIT_CYCLES=0 SHALL give zero-wait transfers: pready=1 in the first ACCESS cycle.
REQ-022 On a completing edge (pready=1): psel=1 and penable=0 -> SETUP (back-to-back); psel=0 -> IDLE.
REQ-023 If psel or penable drops in ACCESS before pready, SHALL return to IDLE with no write and no error.
REQ-024 Error condition SHALL be paddr >= DEPTH, evaluated on the completing cycle.
REQ-025 pslverr SHALL equal pready AND the error condition.
REQ-026 A write SHALL update mem[paddr] at the completing edge, only for bytes whose pstrb bit is 1, and only without error.
REQ-027 A write with pstrb all-zero SHALL complete with pslverr=0 and leave storage unchanged.
REQ-028 An errored write SHALL leave all storage unchanged.
REQ-029 prdata SHALL equal mem[paddr] while pready=1, pwrite=0 and no error; 0 at all other times, including errored reads.
REQ-030 A read in the cycle immediately after a write completes SHALL return the newly written data.
REQ-031 The transfer ends in the same cycle pready is asserted; the bus may change paddr, pwrite and pwdata immediately afterwards.

Reset
REQ-032 preset=0 SHALL asynchronously force state=IDLE, wait counter=0, and all DEPTH words to 0.
REQ-033 During reset, outputs SHALL be pready=0, pslverr=0, prdata=0.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer with no storage update.
REQ-035 After reset deasserts, the first transfer SHALL be accepted from IDLE at the next rising edge.

Verification
REQ-036 Defaults: write 0xDEADBEEF to addr 3 with pstrb=0xF, then read addr 3 -> pready high in the first ACCESS cycle of each transfer; prdata=0xDEADBEEF; pslverr=0.
REQ-037 Byte strobes: addr 5 holds 0x11223344; write 0xAABBCCDD with pstrb=0x5; read addr 5 -> 0x11BB33DD.
REQ-038 WAIT_CYCLES=2: write to addr 1 -> pready low for 2 ACCESS cycles and high on the 3rd; storage updates only at that edge.
REQ-039 Out of range, DEPTH=16: write 0x55 to addr 20 -> pready=1, pslverr=1, no storage change; read addr 20 -> prdata=0, pslverr=1.
REQ-040 Back-to-back: two writes then two reads with no IDLE cycle between them -> each completes; read data matches the written data.
REQ-041 Reset abort: with WAIT_CYCLES=3, pulse preset low during ACCESS of a write to addr 2 -> mem[2]=0; outputs are 0 during reset; the next transfer succeeds.
